// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches always win the RAM slot, CPU writes
// are posted through a small FIFO, and CPU reads wait behind every earlier write.
module vram_arbiter #(
  parameter int unsigned WFIFO_DEPTH = 4
) (
  input  logic                         pixel_clock,
  input  logic                         reset,
  input  logic                         vid_slot,
  input  logic [15:0]                  vid_adr,
  output logic [7:0]                   vid_dat,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [15:0]                  cpu_adr,
  input  logic [7:0]                   cpu_wdat,
  output logic                         cpu_ready,
  output logic                         cpu_ack,
  output logic [7:0]                   cpu_rdat,
  output logic [$clog2(WFIFO_DEPTH):0] wfifo_level,
  output logic [15:0]                  ram_adr,
  output logic                         ram_we,
  output logic [7:0]                   ram_wdat,
  input  logic [7:0]                   ram_rdat
);
  localparam int unsigned PTR_W = $clog2(WFIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ADR_W = 16;
  localparam int unsigned DAT_W = 8;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } wentry_t;

  typedef struct packed {
    logic valid;
    logic is_vid;
  } tag_t;

  typedef enum logic [1:0] {GNT_IDLE, GNT_VID, GNT_WR, GNT_RD} grant_e;

  wentry_t          wmem_q [WFIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             rd_pending_q, rd_pending_d;
  logic             rd_inflight_q, rd_inflight_d;
  logic [ADR_W-1:0] rd_adr_q, rd_adr_d;
  tag_t             tag1_q, tag1_d;
  tag_t             tag2_q, tag2_d;
  logic [ADR_W-1:0] ram_adr_q, ram_adr_d;
  logic             ram_we_q, ram_we_d;
  logic [DAT_W-1:0] ram_wdat_q, ram_wdat_d;
  logic [DAT_W-1:0] vid_dat_q, vid_dat_d;
  logic [DAT_W-1:0] cpu_rdat_q, cpu_rdat_d;
  logic             cpu_ack_q, cpu_ack_d;

  grant_e  grant;
  wentry_t head;
  logic    fifo_full;
  logic    push;
  logic    pop;
  logic    rd_accept;

  assign fifo_full = (level_q == LVL_W'(WFIFO_DEPTH));
  assign cpu_ready = !reset && !fifo_full && !rd_pending_q;
  assign push      = cpu_req && cpu_we && cpu_ready;
  assign rd_accept = cpu_req && !cpu_we && cpu_ready;
  assign head      = wmem_q[rd_ptr_q];
  assign pop       = (grant == GNT_WR);

  // Slot grant; a read only goes once every earlier write has drained
  always_comb begin
    grant = GNT_IDLE;
    if (vid_slot) begin
      grant = GNT_VID;
    end else if (level_q != '0) begin
      grant = GNT_WR;
    end else if (rd_pending_q && !rd_inflight_q) begin
      grant = GNT_RD;
    end
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q + LVL_W'(push) - LVL_W'(pop);
    rd_pending_d  = rd_pending_q;
    rd_inflight_d = rd_inflight_q;
    rd_adr_d      = rd_adr_q;
    tag1_d        = '0;
    tag2_d        = tag1_q;
    ram_adr_d     = ram_adr_q;
    ram_we_d      = 1'b0;
    ram_wdat_d    = ram_wdat_q;
    vid_dat_d     = vid_dat_q;
    cpu_rdat_d    = cpu_rdat_q;
    cpu_ack_d     = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case (grant)
      GNT_VID: begin
        ram_adr_d     = vid_adr;
        tag1_d.valid  = 1'b1;
        tag1_d.is_vid = 1'b1;
      end
      GNT_WR: begin
        ram_adr_d  = head.adr;
        ram_wdat_d = head.dat;
        ram_we_d   = 1'b1;
      end
      GNT_RD: begin
        ram_adr_d     = rd_adr_q;
        tag1_d.valid  = 1'b1;
        rd_inflight_d = 1'b1;
      end
      default: ;
    endcase

    // RAM data for a grant two edges back is on ram_rdat now
    if (tag2_q.valid) begin
      if (tag2_q.is_vid) begin
        vid_dat_d = ram_rdat;
      end else begin
        cpu_rdat_d    = ram_rdat;
        cpu_ack_d     = 1'b1;
        rd_pending_d  = 1'b0;
        rd_inflight_d = 1'b0;
      end
    end

    if (rd_accept) begin
      rd_pending_d = 1'b1;
      rd_adr_d     = cpu_adr;
    end
  end

  // FIFO storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge pixel_clock) begin
    if (push) wmem_q[wr_ptr_q] <= '{adr: cpu_adr, dat: cpu_wdat};
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      rd_pending_q  <= 1'b0;
      rd_inflight_q <= 1'b0;
      rd_adr_q      <= '0;
      tag1_q        <= '0;
      tag2_q        <= '0;
      ram_adr_q     <= '0;
      ram_we_q      <= 1'b0;
      ram_wdat_q    <= '0;
      vid_dat_q     <= '0;
      cpu_rdat_q    <= '0;
      cpu_ack_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      rd_pending_q  <= rd_pending_d;
      rd_inflight_q <= rd_inflight_d;
      rd_adr_q      <= rd_adr_d;
      tag1_q        <= tag1_d;
      tag2_q        <= tag2_d;
      ram_adr_q     <= ram_adr_d;
      ram_we_q      <= ram_we_d;
      ram_wdat_q    <= ram_wdat_d;
      vid_dat_q     <= vid_dat_d;
      cpu_rdat_q    <= cpu_rdat_d;
      cpu_ack_q     <= cpu_ack_d;
    end
  end

  assign wfifo_level = level_q;
  assign ram_adr     = ram_adr_q;
  assign ram_we      = ram_we_q;
  assign ram_wdat    = ram_wdat_q;
  assign vid_dat     = vid_dat_q;
  assign cpu_rdat    = cpu_rdat_q;
  assign cpu_ack     = cpu_ack_q;

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM arbiter sitting directly upstream of the video controller. It multiplexes the controller's character-cell fetches and CPU reads/writes onto one synchronous 64K×8 RAM port. Video fetches always win. CPU writes are absorbed by a small posted-write FIFO, and CPU reads are ordered behind all earlier writes.

## Interface
Parameters:
- WFIFO_DEPTH, 4, posted-write FIFO entries; power of two, ≥2

Ports:
- pixel_clock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- vid_slot  in  1  one-cycle strobe: this cycle's RAM slot belongs to video
- vid_adr  in  16  video fetch address (the controller's vram address output)
- vid_dat  out  8  last video fetch result (feeds the controller's vram data input)
- cpu_req  in  1  CPU request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_adr  in  16  CPU address
- cpu_wdat  in  8  CPU write data
- cpu_ready  out  1  request accepted on the edge where cpu_req & cpu_ready
- cpu_ack  out  1  one-cycle pulse: read data valid on cpu_rdat
- cpu_rdat  out  8  CPU read data; holds until the next ack
- wfifo_level  out  $clog2(WFIFO_DEPTH)+1  current FIFO occupancy
- ram_adr  out  16  RAM address, registered
- ram_we  out  1  RAM write enable, registered
- ram_wdat  out  8  RAM write data, registered
- ram_rdat  in  8  RAM read data, valid the cycle after the RAM samples ram_adr

## Operation
- **cpu_ready** = !reset & !wfifo_full & !rd_pending. It is combinational.
- **Accepted write:** pushes {cpu_adr, cpu_wdat} into the FIFO.
- **Accepted read:** latches cpu_adr and sets rd_pending.
- **Slot grant**, evaluated every cycle in priority order:
  1. vid_slot → VID
  2. FIFO non-empty → WR (pop head)
  3. rd_pending & FIFO empty & no read already in flight → RD
  4. otherwise IDLE
- **Read ordering:** RD is never granted while any earlier write remains in the FIFO. This guarantees read-after-write coherence.
- **Same-edge push and pop:** a push and a pop on the same edge are both honoured, and occupancy is unchanged.
- **Registered RAM controls on the grant edge E:**
  - VID: ram_adr = vid_adr, ram_we = 0.
  - WR: ram_adr/ram_wdat = FIFO head, ram_we = 1.
  - RD: ram_adr = latched CPU address, ram_we = 0.
  - IDLE: ram_we = 0; ram_adr and ram_wdat hold.
- **Result routing:** a two-stage tag pipe {valid, is_vid} tracks each read grant. At edge E+2:
  - VID grant → vid_dat ← ram_rdat.
  - RD grant → cpu_rdat ← ram_rdat, cpu_ack = 1 for one cycle, rd_pending cleared.
- **Starvation:** back-to-back vid_slot may starve the CPU indefinitely. The FIFO and any pending read are held with no loss.
- **Writes produce no ack.** Completion is visible only through wfifo_level.

## Timing
- **Reset values:** ram_adr 0, ram_we 0, ram_wdat 0, vid_dat 0, cpu_rdat 0, cpu_ack 0, wfifo_level 0, cpu_ready 0 (while reset is high).
- **After reset:** cpu_ready = 1 in the first cycle after reset deasserts.
- **Video latency:** vid_slot sampled at edge E → vid_dat updated at E+2, and holds until the next VID result.
- **CPU read latency:** with an empty FIFO and no vid_slot, a read accepted at edge A is granted at A+1, and cpu_ack is high for the cycle following A+3.
- **CPU read ready:** cpu_ready rises in the same cycle cpu_ack is high.
- **Write latency:** a write accepted at A with an empty FIFO and no vid_slot drives ram_we = 1 after A+1.
- **Full FIFO:** cpu_ready is low whenever the FIFO is full. A req while not ready is ignored, and the CPU must hold its request.
- **Reset mid-operation:**
  - The FIFO is flushed and pending and in-flight reads are dropped.
  - Tags are cleared, so no cpu_ack or vid_dat update occurs for pre-reset grants.
  - vid_dat returns to 0.
- **wfifo_level** reflects the post-edge occupancy.

## Test plan
- **Video fetch:** reset, RAM[0x1234] = 0xA5, vid_adr = 0x1234, pulse vid_slot at edge 5 → vid_dat = 0xA5 from edge 7; ram_we stays 0 throughout.
- **Read-after-write ordering:** write 0x00→0x0100, write 0x3C→0x0101, then read 0x0101 with no vid_slot → two ram_we pulses in order, then cpu_ack with cpu_rdat = 0x3C; cpu_ready is low between read accept and ack.
- **FIFO fill under video starvation:** hold vid_slot = 1 and issue 5 writes → 4 accepted, wfifo_level = 4, cpu_ready = 0; drop vid_slot → 4 writes drain on 4 consecutive edges and cpu_ready returns to 1 after the first pop.
- **Collision:** vid_slot in the same cycle a read is granted-eligible → VID wins; the read is granted the next cycle with ack one cycle later than nominal, and vid_dat and cpu_rdat each get the correct value.
- **Reset mid-operation:** reset with 3 writes queued and a read in flight → no ack, wfifo_level = 0, and none of the queued writes reaches RAM.
- **Simultaneous push and pop:** steady write stream at one per cycle with a level-1 FIFO → level stays 1 and every write appears on the RAM port exactly once, in order.
